sys_ctrl_wb: RTL and testbench
==============================

# sys_ctrl_wb

Parametrised system controller on the wishbone bus: generates the system reset sequence, owns the CPU halt and single-step controls, and selects what drives the board LEDs. It sits in the board top beside `wb_system` and `uart_wb_master`. It lets the host halt, step and soft-reset the system over UART without losing the bus master. The bus master is reset only by `reset`, never by `sys_reset`.

## Interface
Parameters:
- `RESET_CYCLES`, 15: cycles `sys_reset` stays high after any reset trigger (≥1).
- `STEP_CYCLES`, 8: cycles `halt` is released per single-step (≥1).
- `LED_WIDTH`, 4: width of `leds`.
- `NUM_LED_SRC`, 4: number of `LED_WIDTH`-bit slices on `led_src`.
- `HALT_ON_RESET`, 0: reset value of the halt register.

Ports:
- `clock` in 1: system clock.
- `reset` in 1: synchronous, active-high; resets the whole block, including the register file.
- `sys_reset` out 1: reset for `wb_system`/CPU.
- `halt` out 1: halt to `wb_system`.
- `led_src` in `LED_WIDTH*NUM_LED_SRC`: candidate LED sources (e.g. `rom_out`).
- `leds` out `LED_WIDTH`: LED drive.
- `wb_data_i` in 32, `wb_addr_i` in 32, `wb_cyc_i` in 1, `wb_strobe_i` in 1, `wb_we_i` in 1: wishbone slave request (address already decoded externally).
- `wb_data_o` out 32, `wb_ack_o` out 1: wishbone slave response.

## Operation
- Register index = `wb_addr_i[4:2]`:
  - 0 CTRL: [0] halt, RW. [1] soft_reset, W1 pulse, reads 0. [2] step, W1 pulse, reads 0.
  - 1 STATUS, RO: [0] sys_reset. [1] halt output. [2] stepping. [15:8] soft-reset count, saturates at 255.
  - 2 LED_SEL, RW: [7:0] slice index. [8] override enable.
  - 3 LED_OVR, RW: [LED_WIDTH-1:0] override value.
  - 4 ID, RO: 0x4F54_0002.
  - 5–7: read 0; writes ignored but acked.
- Reset sequencer FSM:
  - States: SEQ (counting) and RUN.
  - `reset` or a soft_reset write enters SEQ with the counter at 0.
  - In SEQ, `sys_reset` = 1. Leave for RUN when the counter reaches `RESET_CYCLES-1`.
  - Counter width is `$clog2(RESET_CYCLES+1)`.
- Soft reset:
  - Preserves CTRL.halt, LED_SEL and LED_OVR.
  - Increments the soft-reset count.
  - Aborts any step in progress.
  - A soft reset during SEQ restarts the count from 0.
- Step FSM:
  - States: IDLE and STEP.
  - A step write moves IDLE→STEP only when halt reg = 1, the FSM is in IDLE and the sequencer is in RUN; otherwise the write is ignored.
  - In STEP, a counter runs `STEP_CYCLES` cycles, then returns to IDLE.
- `halt` = halt_reg & ~(step state == STEP).
- A write of CTRL with halt=0 during STEP ends the step immediately.
- If halt=1 and step=1 are written together, halt is applied first and the step is accepted in the same write.
- `leds` selection:
  - Override enabled: `leds` = LED_OVR.
  - Otherwise: `leds` = `led_src` slice selected by LED_SEL.
  - Index ≥ `NUM_LED_SRC` selects slice 0.

## Timing
- Reset values (cycle after `reset` sampled high):
  - `sys_reset` = 1; `halt` = `HALT_ON_RESET`; `wb_ack_o` = 0; `wb_data_o` = 0.
  - `leds` = slice 0 of `led_src`.
- `sys_reset` is high for exactly `RESET_CYCLES` cycles after the last trigger cycle (`reset` deassertion or write-ack cycle).
- Wishbone:
  - `wb_ack_o` is registered: it rises the cycle after `wb_cyc_i & wb_strobe_i` is seen with ack low, and lasts exactly one cycle.
  - A strobe held high gives acks on alternate cycles.
  - `wb_data_o` is valid in the ack cycle and 0 otherwise.
- Write side effects (halt, sys_reset rise, step start, LED change) are visible in the ack cycle.
- The bus stays fully operational while `sys_reset` = 1.
- `leds` is registered: one-cycle latency from `led_src`.

## Structure
- Package `sys_ctrl_pkg` holds:
  - register indices;
  - CTRL/STATUS bit positions;
  - the ID constant;
  - FSM state enums for the sequencer and the step logic.
- Sub-module `reset_seq`: parametrised counter plus SEQ/RUN FSM with a `trigger` input. It is instantiated once and is reusable for other boards.
- The board top instantiates `sys_ctrl_wb`:
  - `sys_reset` drives `wb_system`;
  - `reset` drives `uart_wb_master`.

## Test plan
- Deassert `reset` → `sys_reset` stays 1 for exactly 15 cycles, then 0. `halt` = 0. A read of ID returns 0x4F54_0002 with ack 1 cycle after the strobe.
- Write CTRL=0x1, then CTRL=0x5 → `halt`=1 after the first write; `halt` drops for exactly 8 cycles after the second, then returns to 1. STATUS[2] reads 1 during those 8 cycles.
- With `halt`=0, write CTRL=0x4 → no step; STATUS[2]=0 and `halt` stays 0.
- With halt set, write CTRL=0x3 mid-step → `sys_reset` high for 15 cycles and the step is aborted. `halt` stays 1, and STATUS[15:8] increments by 1. A second soft reset at cycle 5 of the sequence extends `sys_reset` to 5+15 cycles.
- `led_src`=0x4321:
  - LED_SEL=2 → `leds`=0x3.
  - LED_SEL=7 → `leds`=0x1.
  - LED_OVR=0xA with LED_SEL=0x100 → `leds`=0xA.
- Hold strobe high for 6 cycles → ack pattern 0,1,0,1,0,1. A read of index 6 returns 0.

Source files
------------

// File: rtl/sys_ctrl_pkg.sv
// Shared definitions for the wishbone system controller: register map, bit positions, ID, FSM states.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package sys_ctrl_pkg;

  // Register indices, taken from wb_addr_i[4:2]
  localparam logic [2:0] REG_CTRL    = 3'd0;
  localparam logic [2:0] REG_STATUS  = 3'd1;
  localparam logic [2:0] REG_LED_SEL = 3'd2;
  localparam logic [2:0] REG_LED_OVR = 3'd3;
  localparam logic [2:0] REG_ID      = 3'd4;

  // CTRL bit positions
  localparam int CTRL_HALT     = 0;
  localparam int CTRL_SOFT_RST = 1;
  localparam int CTRL_STEP     = 2;

  // STATUS bit positions
  localparam int STAT_SYS_RESET    = 0;
  localparam int STAT_HALT         = 1;
  localparam int STAT_STEPPING     = 2;
  localparam int STAT_SRST_CNT_LSB = 8;

  // LED_SEL override enable bit
  localparam int LED_SEL_OVR_EN = 8;

  localparam logic [31:0] SYS_CTRL_ID = 32'h4F54_0002;

  typedef enum logic {SEQ_COUNT, SEQ_RUN} seq_state_e;
  typedef enum logic {STEP_IDLE, STEP_ACTIVE} step_state_e;

endpackage

// File: rtl/reset_seq.sv
// Reset sequencer: holds sys_reset high for RESET_CYCLES cycles after rst or a trigger pulse.
// Latency: sys_reset rises the cycle after the trigger; a retrigger restarts the count.
// Backpressure: none; trigger is accepted every cycle.
module reset_seq #(
  parameter int RESET_CYCLES = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic trigger,
  output logic sys_reset
);
  import sys_ctrl_pkg::*;

  localparam int CW = $clog2(RESET_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(RESET_CYCLES - 1);

  seq_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Next-state: a trigger always restarts counting from zero, otherwise count up to LAST then run
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (trigger) begin
      state_d = SEQ_COUNT;
      cnt_d   = '0;
    end else if (state_q == SEQ_COUNT) begin
      if (cnt_q == LAST) begin
        state_d = SEQ_RUN;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // State and counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SEQ_COUNT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign sys_reset = (state_q == SEQ_COUNT);

endmodule

// File: rtl/sys_ctrl_wb.sv
// System controller on wishbone: reset sequencing, CPU halt/single-step, LED source selection.
// Latency: registered ack one cycle after strobe; write side effects and LED changes visible in the ack cycle.
// Backpressure: none; a held strobe is acked on alternate cycles.
module sys_ctrl_wb #(
  parameter int RESET_CYCLES  = 15,
  parameter int STEP_CYCLES   = 8,
  parameter int LED_WIDTH     = 4,
  parameter int NUM_LED_SRC   = 4,
  parameter int HALT_ON_RESET = 0
) (
  input  logic                             clock,
  input  logic                             reset,
  output logic                             sys_reset,
  output logic                             halt,
  input  logic [LED_WIDTH*NUM_LED_SRC-1:0] led_src,
  output logic [LED_WIDTH-1:0]             leds,
  input  logic [31:0]                      wb_data_i,
  input  logic [31:0]                      wb_addr_i,
  input  logic                             wb_cyc_i,
  input  logic                             wb_strobe_i,
  input  logic                             wb_we_i,
  output logic [31:0]                      wb_data_o,
  output logic                             wb_ack_o
);
  import sys_ctrl_pkg::*;

  localparam int SW = $clog2(STEP_CYCLES + 1);
  localparam logic [SW-1:0] STEP_LAST = SW'(STEP_CYCLES - 1);

  logic                 ack_q, ack_d;
  logic [31:0]          data_q, data_d;
  logic                 halt_q, halt_d;
  logic [7:0]           srst_cnt_q, srst_cnt_d;
  logic [8:0]           led_sel_q, led_sel_d;
  logic [LED_WIDTH-1:0] led_ovr_q, led_ovr_d;
  logic [LED_WIDTH-1:0] leds_q, leds_d;
  step_state_e          step_state_q, step_state_d;
  logic [SW-1:0]        step_cnt_q, step_cnt_d;

  logic                 req, wr, ctrl_wr, soft_rst;
  logic [2:0]           idx;
  logic [31:0]          rdata;
  logic [LED_WIDTH-1:0] led_slice;
  logic                 unused_ok;

  assign unused_ok = ^{wb_addr_i[31:5], wb_addr_i[1:0], wb_data_i[31:9]};

  reset_seq #(.RESET_CYCLES(RESET_CYCLES)) u_reset_seq (
    .clk      (clock),
    .rst      (reset),
    .trigger  (soft_rst),
    .sys_reset(sys_reset)
  );

  // Bus decode: a new request is only taken while ack is low, giving alternate-cycle acks
  always_comb begin
    req      = wb_cyc_i & wb_strobe_i & ~ack_q;
    wr       = req & wb_we_i;
    idx      = wb_addr_i[4:2];
    ctrl_wr  = wr & (idx == REG_CTRL);
    soft_rst = ctrl_wr & wb_data_i[CTRL_SOFT_RST];
  end

  // Register next values; halt is updated before the step check so halt+step in one write works
  always_comb begin
    halt_d     = ctrl_wr ? wb_data_i[CTRL_HALT] : halt_q;
    led_sel_d  = (wr && idx == REG_LED_SEL) ? wb_data_i[8:0] : led_sel_q;
    led_ovr_d  = (wr && idx == REG_LED_OVR) ? wb_data_i[LED_WIDTH-1:0] : led_ovr_q;
    srst_cnt_d = (soft_rst && srst_cnt_q != 8'hFF) ? srst_cnt_q + 8'd1 : srst_cnt_q;
  end

  // Step FSM: soft reset or clearing halt aborts; a step is only taken when halted, idle and running
  always_comb begin
    step_state_d = step_state_q;
    step_cnt_d   = step_cnt_q;
    if (soft_rst || (ctrl_wr && !wb_data_i[CTRL_HALT])) begin
      step_state_d = STEP_IDLE;
      step_cnt_d   = '0;
    end else if (step_state_q == STEP_IDLE) begin
      if (ctrl_wr && wb_data_i[CTRL_STEP] && halt_d && !sys_reset) begin
        step_state_d = STEP_ACTIVE;
        step_cnt_d   = '0;
      end
    end else if (step_cnt_q == STEP_LAST) begin
      step_state_d = STEP_IDLE;
      step_cnt_d   = '0;
    end else begin
      step_cnt_d = step_cnt_q + 1'b1;
    end
  end

  // LED mux works from next-cycle select values so a register write shows in its ack cycle
  always_comb begin
    led_slice = led_src[LED_WIDTH-1:0];
    for (int i = 0; i < NUM_LED_SRC; i++) begin
      if (led_sel_d[7:0] == 8'(i)) led_slice = led_src[i*LED_WIDTH +: LED_WIDTH];
    end
    leds_d = led_sel_d[LED_SEL_OVR_EN] ? led_ovr_d : led_slice;
  end

  // Read mux and registered response; data is zero outside the ack cycle
  always_comb begin
    rdata = '0;
    case (idx)
      REG_CTRL:    rdata[CTRL_HALT] = halt_q;
      REG_STATUS: begin
        rdata[STAT_SYS_RESET]              = sys_reset;
        rdata[STAT_HALT]                   = halt;
        rdata[STAT_STEPPING]               = (step_state_q == STEP_ACTIVE);
        rdata[STAT_SRST_CNT_LSB +: 8]      = srst_cnt_q;
      end
      REG_LED_SEL: rdata[8:0] = led_sel_q;
      REG_LED_OVR: rdata[LED_WIDTH-1:0] = led_ovr_q;
      REG_ID:      rdata = SYS_CTRL_ID;
      default:     rdata = '0;
    endcase
    ack_d  = req;
    data_d = (req && !wb_we_i) ? rdata : 32'd0;
  end

  // All controller state; reset is the only thing that clears the register file
  always_ff @(posedge clock) begin
    if (reset) begin
      ack_q        <= 1'b0;
      data_q       <= '0;
      halt_q       <= 1'(HALT_ON_RESET);
      srst_cnt_q   <= '0;
      led_sel_q    <= '0;
      led_ovr_q    <= '0;
      leds_q       <= led_src[LED_WIDTH-1:0];
      step_state_q <= STEP_IDLE;
      step_cnt_q   <= '0;
    end else begin
      ack_q        <= ack_d;
      data_q       <= data_d;
      halt_q       <= halt_d;
      srst_cnt_q   <= srst_cnt_d;
      led_sel_q    <= led_sel_d;
      led_ovr_q    <= led_ovr_d;
      leds_q       <= leds_d;
      step_state_q <= step_state_d;
      step_cnt_q   <= step_cnt_d;
    end
  end

  assign halt      = halt_q & (step_state_q != STEP_ACTIVE);
  assign leds      = leds_q;
  assign wb_ack_o  = ack_q;
  assign wb_data_o = data_q;

endmodule

// File: tb/tb_sys_ctrl_wb.sv
// Directed self-checking bench for sys_ctrl_wb with default parameters.
// Latency: inputs driven 1 time unit after posedge, outputs sampled at the same point.
// Backpressure: bus transfers wait for ack with a bounded cycle budget.
module tb_sys_ctrl_wb;

  logic        clock = 1'b0;
  logic        reset;
  logic        sys_reset, halt;
  logic [15:0] led_src;
  logic [3:0]  leds;
  logic [31:0] wb_data_i, wb_addr_i, wb_data_o;
  logic        wb_cyc_i, wb_strobe_i, wb_we_i, wb_ack_o;

  int checks = 0;
  int errors = 0;

  sys_ctrl_wb #(
    .RESET_CYCLES(15), .STEP_CYCLES(8), .LED_WIDTH(4), .NUM_LED_SRC(4), .HALT_ON_RESET(0)
  ) dut (
    .clock(clock), .reset(reset), .sys_reset(sys_reset), .halt(halt),
    .led_src(led_src), .leds(leds),
    .wb_data_i(wb_data_i), .wb_addr_i(wb_addr_i), .wb_cyc_i(wb_cyc_i),
    .wb_strobe_i(wb_strobe_i), .wb_we_i(wb_we_i),
    .wb_data_o(wb_data_o), .wb_ack_o(wb_ack_o)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // One bus transfer; returns read data and the number of cycles until ack
  task automatic bus_xfer(input logic we, input logic [2:0] idx, input logic [31:0] wd,
                          output logic [31:0] rd, output int waits);
    wb_cyc_i    = 1'b1;
    wb_strobe_i = 1'b1;
    wb_we_i     = we;
    wb_addr_i   = {27'd0, idx, 2'b00};
    wb_data_i   = wd;
    waits = 0;
    do begin
      tick();
      waits++;
    end while (!wb_ack_o && waits < 8);
    check("bus_ack", {31'd0, wb_ack_o}, 32'd1);
    rd          = wb_data_o;
    wb_cyc_i    = 1'b0;
    wb_strobe_i = 1'b0;
    wb_we_i     = 1'b0;
  endtask

  task automatic bus_write(input logic [2:0] idx, input logic [31:0] wd);
    logic [31:0] rd;
    int w;
    bus_xfer(1'b1, idx, wd, rd, w);
  endtask

  task automatic bus_read(input logic [2:0] idx, output logic [31:0] rd);
    int w;
    bus_xfer(1'b0, idx, 32'd0, rd, w);
  endtask

  initial begin
    logic [31:0] rd;
    logic [5:0]  pat;
    int n, w;

    reset = 1'b1; led_src = 16'h4321;
    wb_data_i = '0; wb_addr_i = '0; wb_cyc_i = 0; wb_strobe_i = 0; wb_we_i = 0;
    tick(); tick();
    check("rst_sys_reset", {31'd0, sys_reset}, 32'd1);
    check("rst_halt", {31'd0, halt}, 32'd0);
    check("rst_ack", {31'd0, wb_ack_o}, 32'd0);
    check("rst_data", wb_data_o, 32'd0);
    check("rst_leds", {28'd0, leds}, 32'h1);

    // Power-on sequence: exactly 15 cycles of sys_reset after reset drops
    reset = 1'b0;
    n = 0;
    while (sys_reset && n < 100) begin n++; tick(); end
    check("por_len", n, 15);
    check("por_halt", {31'd0, halt}, 32'd0);

    // ID read acked exactly one cycle after the strobe; bus idle afterwards
    bus_xfer(1'b0, 3'd4, 32'd0, rd, w);
    check("id_data", rd, 32'h4F54_0002);
    check("id_latency", w, 1);
    tick();
    check("post_ack", {31'd0, wb_ack_o}, 32'd0);
    check("post_data", wb_data_o, 32'd0);

    // Halt, then single step: halt low for exactly 8 cycles
    bus_write(3'd0, 32'h1);
    check("halt_set", {31'd0, halt}, 32'd1);
    bus_write(3'd0, 32'h5);
    n = 0;
    while (!halt && n < 50) begin n++; tick(); end
    check("step_len", n, 8);
    check("step_done_halt", {31'd0, halt}, 32'd1);

    // Second step: STATUS shows stepping mid-step, remaining low cycles add up to 8
    bus_write(3'd0, 32'h5);
    bus_read(3'd1, rd);
    check("status_stepping", rd, 32'h4);
    n = 0;
    while (!halt && n < 50) begin n++; tick(); end
    check("step_rest", n, 6);
    bus_read(3'd1, rd);
    check("status_halted", rd, 32'h2);

    // Step ignored while not halted
    bus_write(3'd0, 32'h0);
    bus_write(3'd0, 32'h4);
    check("nostep_halt", {31'd0, halt}, 32'd0);
    tick();
    check("nostep_halt2", {31'd0, halt}, 32'd0);
    bus_read(3'd1, rd);
    check("nostep_status", rd, 32'h0);

    // Soft reset mid-step: step aborted, halt kept, bus usable during the sequence
    bus_write(3'd0, 32'h1);
    bus_write(3'd0, 32'h5);
    tick(); tick();
    bus_write(3'd0, 32'h3);
    check("srst_rise", {31'd0, sys_reset}, 32'd1);
    check("srst_halt", {31'd0, halt}, 32'd1);
    bus_read(3'd1, rd);
    check("srst_status_seq", rd, 32'h103);
    n = 0;
    while (sys_reset && n < 100) begin n++; tick(); end
    check("srst_rest", n, 13);
    bus_read(3'd1, rd);
    check("srst_status_run", rd, 32'h102);

    // Retrigger at cycle 5 of the sequence extends sys_reset to 20 cycles
    bus_write(3'd0, 32'h3);
    n = 0;
    repeat (5) begin if (sys_reset) n++; if (n < 5) tick(); end
    bus_write(3'd0, 32'h3);
    while (sys_reset && n < 100) begin n++; tick(); end
    check("srst_extend", n, 20);
    check("srst2_halt", {31'd0, halt}, 32'd1);
    bus_read(3'd1, rd);
    check("srst_count", rd, 32'h302);
    bus_read(3'd0, rd);
    check("ctrl_readback", rd, 32'h1);

    // LED selection
    bus_write(3'd2, 32'h2);
    check("led_sel2", {28'd0, leds}, 32'h3);
    bus_write(3'd2, 32'h7);
    check("led_sel7", {28'd0, leds}, 32'h1);
    bus_write(3'd3, 32'hA);
    bus_write(3'd2, 32'h100);
    check("led_ovr", {28'd0, leds}, 32'hA);
    bus_write(3'd2, 32'h1);
    check("led_sel1", {28'd0, leds}, 32'h2);
    led_src = 16'h8765;
    check("led_latency_old", {28'd0, leds}, 32'h2);
    tick();
    check("led_latency_new", {28'd0, leds}, 32'h6);
    bus_read(3'd2, rd);
    check("led_sel_rb", rd, 32'h1);
    bus_read(3'd3, rd);
    check("led_ovr_rb", rd, 32'hA);

    // Held strobe gives alternate-cycle acks; unmapped index reads zero
    tick();
    wb_cyc_i = 1'b1; wb_strobe_i = 1'b1; wb_we_i = 1'b0; wb_addr_i = 32'h18;
    pat = '0;
    for (int i = 0; i < 6; i++) begin
      pat = {pat[4:0], wb_ack_o};
      if (wb_ack_o) check("idx6_data", wb_data_o, 32'd0);
      tick();
    end
    wb_cyc_i = 1'b0; wb_strobe_i = 1'b0;
    check("ack_pattern", {26'd0, pat}, 32'h15);
    bus_write(3'd7, 32'hFFFF_FFFF);
    bus_read(3'd0, rd);
    check("idx7_no_effect", rd, 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
